// File: rtl/light_centroid_stats_pkg.sv
// Shared types and default geometry for the light-pixel centroid statistics block.
// Optional bounding-box outputs are enabled with FRAME_STATS_BBOX_EN.
package light_centroid_stats_pkg;

  localparam int H_ACTIVE_D = 640;
  localparam int V_ACTIVE_D = 480;
  localparam int DATA_W_D   = 10;
  localparam int CNT_W_D    = 19;
  localparam int SUM_W_D    = 28;
  localparam int COORD_W    = 10;

  // One load cycle plus one iteration per dividend bit.
  localparam int DIV_CYCLES = SUM_W_D + 1;

  typedef enum logic [1:0] {
    ACCUM,
    DIV_X,
    DIV_Y,
    PUBLISH
  } state_t;

endpackage

// File: rtl/light_centroid_stats_divider.sv
// Restoring serial divider: one load cycle, then one quotient bit per cycle.
// done is high during the final iteration; quot is valid in that same cycle.
module serial_divider
  import light_centroid_stats_pkg::*;
#(
  parameter int NUM_W  = SUM_W_D,
  parameter int DEN_W  = CNT_W_D,
  parameter int CYCLES = DIV_CYCLES
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               start,
  input  logic [NUM_W-1:0]   numer,
  input  logic [DEN_W-1:0]   denom,
  output logic               busy,
  output logic               done,
  output logic [COORD_W-1:0] quot
);

  localparam int ITERS = CYCLES - 1;
  localparam int IW    = $clog2(ITERS + 1);

  logic [IW-1:0]    iter;
  logic [DEN_W-1:0] rem;
  logic [DEN_W-1:0] dvs;
  logic [NUM_W-1:0] dvd;

  logic [DEN_W:0]   shifted;
  logic [DEN_W:0]   diff;
  logic             ge;
  logic [DEN_W-1:0] remNext;
  logic [NUM_W-1:0] dvdNext;

  always_comb begin
    shifted = {rem, dvd[NUM_W-1]};
    ge      = shifted >= {1'b0, dvs};
    diff    = shifted - {1'b0, dvs};
    remNext = ge ? diff[DEN_W-1:0] : shifted[DEN_W-1:0];
    dvdNext = {dvd[NUM_W-2:0], ge};
  end

  assign done = busy && (iter == IW'(ITERS - 1));
  assign quot = dvdNext[COORD_W-1:0];

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      busy <= 1'b0;
      iter <= '0;
      rem  <= '0;
      dvs  <= '0;
      dvd  <= '0;
    end else if (start && !busy) begin
      busy <= 1'b1;
      iter <= '0;
      rem  <= '0;
      dvs  <= denom;
      dvd  <= numer;
    end else if (busy) begin
      rem  <= remNext;
      dvd  <= dvdNext;
      iter <= iter + 1'b1;
      if (done)
        busy <= 1'b0;
    end
  end

endmodule

// File: rtl/light_centroid_stats.sv
// Per-frame light-pixel count and integer centroid from the cropped pixel stream.
// FRAME_STATS_BBOX_EN adds a bounding box of light pixels to the published stats.
module light_centroid_stats
  import light_centroid_stats_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int DATA_W   = DATA_W_D,
  parameter int CNT_W    = CNT_W_D,
  parameter int SUM_W    = SUM_W_D
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iDVAL,
  input  logic [DATA_W-1:0]  iDATA,
  input  logic [DATA_W-1:0]  iTHRESH,
  output logic [CNT_W-1:0]   oCOUNT,
  output logic [COORD_W-1:0] oCX,
  output logic [COORD_W-1:0] oCY,
  output logic               oEMPTY,
  output logic               oSTAT_VALID,
  output logic               oBUSY,
`ifdef FRAME_STATS_BBOX_EN
  output logic [COORD_W-1:0] oXMIN,
  output logic [COORD_W-1:0] oXMAX,
  output logic [COORD_W-1:0] oYMIN,
  output logic [COORD_W-1:0] oYMAX,
`endif
  output logic               oOVERRUN
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);

  state_t state, stateNext;

  logic [COORD_W-1:0] xPos, yPos;
  logic [CNT_W-1:0]   cnt, cntNext, holdCnt;
  logic [SUM_W-1:0]   sumX, sumXNext, holdSx;
  logic [SUM_W-1:0]   sumY, sumYNext, holdSy;
  logic [COORD_W-1:0] cxR, cyR;

  logic light, xLast, yLast, frameEnd, accept, holdEmpty;

  logic               divStart, divBusy, divDone;
  logic [SUM_W-1:0]   divNumer;
  logic [COORD_W-1:0] divQuot;

  assign xLast     = xPos == X_LAST;
  assign yLast     = yPos == Y_LAST;
  assign frameEnd  = iDVAL && xLast && yLast;
  assign accept    = frameEnd && (state == ACCUM);
  assign light     = iDVAL && (iDATA != '0) && (iDATA >= iTHRESH);
  assign holdEmpty = holdCnt == '0;
  assign oBUSY     = (state == DIV_X) || (state == DIV_Y);

  // Accumulator values including the pixel on the current edge.
  always_comb begin
    cntNext  = cnt;
    sumXNext = sumX;
    sumYNext = sumY;
    if (light) begin
      cntNext  = cnt + 1'b1;
      sumXNext = sumX + SUM_W'(xPos);
      sumYNext = sumY + SUM_W'(yPos);
    end
  end

`ifdef FRAME_STATS_BBOX_EN
  logic [COORD_W-1:0] xMin, xMax, yMin, yMax;
  logic [COORD_W-1:0] xMinN, xMaxN, yMinN, yMaxN;
  logic [COORD_W-1:0] hXMin, hXMax, hYMin, hYMax;

  always_comb begin
    xMinN = xMin;
    xMaxN = xMax;
    yMinN = yMin;
    yMaxN = yMax;
    if (light && cnt == '0) begin
      xMinN = xPos;
      xMaxN = xPos;
      yMinN = yPos;
      yMaxN = yPos;
    end else if (light) begin
      if (xPos < xMin) xMinN = xPos;
      if (xPos > xMax) xMaxN = xPos;
      if (yPos < yMin) yMinN = yPos;
      if (yPos > yMax) yMaxN = yPos;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      {xMin, xMax, yMin, yMax} <= '0;
      {hXMin, hXMax, hYMin, hYMax} <= '0;
      {oXMIN, oXMAX, oYMIN, oYMAX} <= '0;
    end else begin
      if (frameEnd) begin
        {xMin, xMax, yMin, yMax} <= '0;
      end else begin
        {xMin, xMax, yMin, yMax} <= {xMinN, xMaxN, yMinN, yMaxN};
      end
      if (accept)
        {hXMin, hXMax, hYMin, hYMax} <= {xMinN, xMaxN, yMinN, yMaxN};
      if (state == PUBLISH) begin
        oXMIN <= holdEmpty ? '0 : hXMin;
        oXMAX <= holdEmpty ? '0 : hXMax;
        oYMIN <= holdEmpty ? '0 : hYMin;
        oYMAX <= holdEmpty ? '0 : hYMax;
      end
    end
  end
`endif

  always_comb begin
    stateNext = state;
    unique case (state)
      ACCUM:   if (accept) stateNext = (cntNext == '0) ? PUBLISH : DIV_X;
      DIV_X:   if (divDone) stateNext = DIV_Y;
      DIV_Y:   if (divDone) stateNext = PUBLISH;
      PUBLISH: stateNext = ACCUM;
      default: stateNext = ACCUM;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) state <= ACCUM;
    else      state <= stateNext;
  end

  assign divStart = oBUSY && !divBusy;
  assign divNumer = (state == DIV_Y) ? holdSy : holdSx;

  serial_divider #(
    .NUM_W  (SUM_W),
    .DEN_W  (CNT_W),
    .CYCLES (SUM_W + 1)
  ) uDiv (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .start (divStart),
    .numer (divNumer),
    .denom (holdCnt),
    .busy  (divBusy),
    .done  (divDone),
    .quot  (divQuot)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      xPos        <= '0;
      yPos        <= '0;
      cnt         <= '0;
      sumX        <= '0;
      sumY        <= '0;
      holdCnt     <= '0;
      holdSx      <= '0;
      holdSy      <= '0;
      cxR         <= '0;
      cyR         <= '0;
      oCOUNT      <= '0;
      oCX         <= '0;
      oCY         <= '0;
      oEMPTY      <= 1'b0;
      oSTAT_VALID <= 1'b0;
      oOVERRUN    <= 1'b0;
    end else begin
      if (iDVAL) begin
        if (xLast) begin
          xPos <= '0;
          yPos <= yLast ? '0 : yPos + 1'b1;
        end else begin
          xPos <= xPos + 1'b1;
        end
      end
      // The frame-end pixel lands in the snapshot; the next frame starts clean.
      if (frameEnd) begin
        cnt  <= '0;
        sumX <= '0;
        sumY <= '0;
      end else begin
        cnt  <= cntNext;
        sumX <= sumXNext;
        sumY <= sumYNext;
      end
      if (accept) begin
        holdCnt <= cntNext;
        holdSx  <= sumXNext;
        holdSy  <= sumYNext;
      end
      if (frameEnd && state != ACCUM)
        oOVERRUN <= 1'b1;
      if (state == DIV_X && divDone) cxR <= divQuot;
      if (state == DIV_Y && divDone) cyR <= divQuot;
      oSTAT_VALID <= state == PUBLISH;
      if (state == PUBLISH) begin
        oCOUNT <= holdCnt;
        oEMPTY <= holdEmpty;
        oCX    <= holdEmpty ? '0 : cxR;
        oCY    <= holdEmpty ? '0 : cyR;
      end
    end
  end

endmodule

// File: tb/tb_light_centroid_stats.sv
// Randomized scoreboard bench for light_centroid_stats on a small 8x6 raster.
// Frame statistics are computed by plain arithmetic over each generated frame.
module tb_light_centroid_stats;

  localparam int H     = 8;
  localparam int V     = 6;
  localparam int FRAME = H * V;
  localparam int LAT   = 2 * (28 + 1) + 1;

  typedef struct {
    int cnt; int cx; int cy; int emp;
    int xmn; int xmx; int ymn; int ymx;
    int cyc;
  } exp_t;

  logic        iCLK, iRST, iDVAL;
  logic [9:0]  iDATA, iTHRESH;
  logic [18:0] oCOUNT;
  logic [9:0]  oCX, oCY;
  logic        oEMPTY, oSTAT_VALID, oBUSY, oOVERRUN;
`ifdef FRAME_STATS_BBOX_EN
  logic [9:0]  oXMIN, oXMAX, oYMIN, oYMAX;
`endif

  light_centroid_stats #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iDVAL       (iDVAL),
    .iDATA       (iDATA),
    .iTHRESH     (iTHRESH),
    .oCOUNT      (oCOUNT),
    .oCX         (oCX),
    .oCY         (oCY),
    .oEMPTY      (oEMPTY),
    .oSTAT_VALID (oSTAT_VALID),
    .oBUSY       (oBUSY),
`ifdef FRAME_STATS_BBOX_EN
    .oXMIN       (oXMIN),
    .oXMAX       (oXMAX),
    .oYMIN       (oYMIN),
    .oYMAX       (oYMAX),
`endif
    .oOVERRUN    (oOVERRUN)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int   cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  int   nChecks = 0;
  int   nPass = 0;
  exp_t q[$];
  int   pix[FRAME];
  int   thr;
  int   lastEnd = -1000;
  int   lastLat = 0;
  int   busyLo = 0;
  int   busyHi = -1;
  int   expOv = 0;
  bit   monOn = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic step(input logic v, input logic [9:0] d);
    iDVAL = v;
    iDATA = d;
    @(posedge iCLK);
    #1;
  endtask

  function automatic exp_t model();
    exp_t e;
    int sx, sy;
    e = '{default: 0};
    sx = 0;
    sy = 0;
    e.xmn = H; e.ymn = V; e.xmx = -1; e.ymx = -1;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        if (pix[y*H+x] != 0 && pix[y*H+x] >= thr) begin
          e.cnt++;
          sx += x;
          sy += y;
          if (x < e.xmn) e.xmn = x;
          if (x > e.xmx) e.xmx = x;
          if (y < e.ymn) e.ymn = y;
          if (y > e.ymx) e.ymx = y;
        end
    if (e.cnt == 0) begin
      e.emp = 1;
      e.xmn = 0; e.xmx = 0; e.ymn = 0; e.ymx = 0;
    end else begin
      e.cx = sx / e.cnt;
      e.cy = sy / e.cnt;
    end
    return e;
  endfunction

  task automatic book(input exp_t e, input int t);
    if (t <= lastEnd + lastLat) begin
      expOv = 1;
    end else begin
      lastLat = (e.cnt != 0) ? LAT : 1;
      e.cyc = t + lastLat;
      q.push_back(e);
      lastEnd = t;
      if (e.cnt != 0) begin
        busyLo = t;
        busyHi = t + LAT - 2;
      end
    end
  endtask

  task automatic send_frame(input bit gaps, input int idle);
    int t;
    iTHRESH = 10'(thr);
    for (int i = 0; i < FRAME; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) step(1'b0, 10'($urandom));
      step(1'b1, 10'(pix[i]));
    end
    t = cyc;
    book(model(), t);
    repeat (idle) step(1'b0, 10'($urandom));
  endtask

  task automatic clear_frame();
    for (int i = 0; i < FRAME; i++) pix[i] = 0;
  endtask

  task automatic rand_frame(input int dens);
    for (int i = 0; i < FRAME; i++)
      pix[i] = ($urandom_range(0, 99) < dens) ? int'($urandom_range(0, 1023)) : 0;
    thr = $urandom_range(0, 1023);
  endtask

  always @(negedge iCLK) begin
    if (monOn && !iRST) begin
      automatic int expStrobe = (q.size() > 0 && q[0].cyc == cyc) ? 1 : 0;
      chk("busy", int'(oBUSY), (cyc >= busyLo && cyc <= busyHi) ? 1 : 0);
      chk("overrun", int'(oOVERRUN), expOv);
      chk("strobe", int'(oSTAT_VALID), expStrobe);
      if (expStrobe == 1) begin
        automatic exp_t e = q.pop_front();
        if (oSTAT_VALID) begin
          chk("count", int'(oCOUNT), e.cnt);
          chk("cx", int'(oCX), e.cx);
          chk("cy", int'(oCY), e.cy);
          chk("empty", int'(oEMPTY), e.emp);
`ifdef FRAME_STATS_BBOX_EN
          chk("xmin", int'(oXMIN), e.xmn);
          chk("xmax", int'(oXMAX), e.xmx);
          chk("ymin", int'(oYMIN), e.ymn);
          chk("ymax", int'(oYMAX), e.ymx);
`endif
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_count"}, int'(oCOUNT), 0);
    chk({tag, "_cx"}, int'(oCX), 0);
    chk({tag, "_cy"}, int'(oCY), 0);
    chk({tag, "_empty"}, int'(oEMPTY), 0);
    chk({tag, "_strobe"}, int'(oSTAT_VALID), 0);
    chk({tag, "_busy"}, int'(oBUSY), 0);
    chk({tag, "_overrun"}, int'(oOVERRUN), 0);
  endtask

  initial begin
    int t;
    iRST = 1'b1;
    iDVAL = 1'b0;
    iDATA = '0;
    iTHRESH = '0;
    repeat (3) @(posedge iCLK);
    #1;
    chk_zero("reset");
    iRST = 1'b0;
    monOn = 1;

    clear_frame(); thr = 512; pix[3*H+5] = 900;
    send_frame(0, 70);
    clear_frame(); thr = 512;
    send_frame(0, 70);
    clear_frame(); thr = 1;
    for (int y = 1; y <= 3; y++)
      for (int x = 2; x <= 5; x++) pix[y*H+x] = 1023;
    send_frame(1, 70);
    clear_frame(); thr = 300; pix[1*H+1] = 300; pix[2*H+2] = 299;
    send_frame(0, 70);
    for (int i = 0; i < FRAME; i++) pix[i] = 1023;
    thr = 0;
    send_frame(0, 70);
    clear_frame(); thr = 0; pix[FRAME-1] = 7;
    send_frame(0, 70);
    for (int k = 0; k < 10; k++) begin
      rand_frame($urandom_range(5, 95));
      send_frame(1, 70);
    end

    clear_frame(); thr = 100; pix[2*H+6] = 200;
    send_frame(0, 0);
    rand_frame(50);
    send_frame(0, 0);
    rand_frame(50);
    send_frame(0, 70);

    clear_frame(); thr = 10; pix[4*H+3] = 50; pix[5*H+7] = 60;
    send_frame(0, 0);
    t = lastEnd;
    while (cyc < t + 33) step(1'b0, 10'($urandom));
    void'(q.pop_back());
    iRST = 1'b1;
    step(1'b0, '0);
    iRST = 1'b0;
    busyHi = -1;
    expOv = 0;
    lastEnd = -1000;
    chk_zero("midreset");

    rand_frame(60);
    send_frame(1, 70);
    clear_frame(); thr = 1; pix[0] = 1; pix[FRAME-1] = 1;
    send_frame(0, 0);

    for (int i = 0; i < 200 && q.size() > 0; i++) step(1'b0, '0);
    chk("drain", q.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/light_centroid_stats.md
Name: light_centroid_stats

Overview:
- Sits directly downstream of the image crop stage and consumes its cropped 10-bit pixel stream.
- Counts "light" pixels per frame and accumulates their X/Y coordinate sums.
- At frame end it divides the sums by the count with a serial divider and publishes the light-pixel count and the integer centroid (CX, CY) with a one-cycle valid strobe.
- Used by tracking/decision logic that needs target position, not raw pixels.

Parameters:
- H_ACTIVE, 640, pixels per line (X raster length).
- V_ACTIVE, 480, lines per frame.
- DATA_W, 10, pixel width.
- CNT_W, 19, light-count width (holds H_ACTIVE*V_ACTIVE).
- SUM_W, 28, coordinate-sum width (holds count*(H_ACTIVE-1)).

Ports:
- iCLK  in  1  clock; single clock domain.
- iRST  in  1  reset; synchronous, active-high.
- iDVAL  in  1  pixel valid from crop stage.
- iDATA  in  DATA_W  cropped pixel; cropped-away pixels arrive as 0.
- iTHRESH  in  DATA_W  light threshold; pixel is light when iDATA >= iTHRESH and iDATA != 0.
- oCOUNT  out  CNT_W  light pixels in last completed frame.
- oCX  out  10  floor(sumX/count).
- oCY  out  10  floor(sumY/count).
- oEMPTY  out  1  last frame had zero light pixels.
- oSTAT_VALID  out  1  one-cycle strobe when the outputs above update.
- oBUSY  out  1  divide in progress.
- oOVERRUN  out  1  sticky; frame end arrived while busy.

Behaviour:
- Reset: all outputs 0; X/Y counters, accumulators and hold registers 0; FSM to ACCUM. Takes effect on the next iCLK edge, including mid-divide. An aborted divide produces no strobe.
- Raster counters:
  - X increments on each iDVAL pixel; wraps at H_ACTIVE-1 to 0 and increments Y.
  - Y wraps at V_ACTIVE-1 to 0.
  - Pixels are counted only when iDVAL=1; iDVAL=0 cycles are ignored.
- Accumulate: on a light pixel, cnt+=1, sumX+=X, sumY+=Y, using pre-increment X/Y.
- Frame end: the pixel accepted at X=H_ACTIVE-1, Y=V_ACTIVE-1, sampled at edge T.
  - At edge T the final pixel's contribution is included in the snapshot.
  - Accumulators are copied to hold registers and cleared in the same edge.
  - The next frame accumulates with no lost pixel.
- FSM states: ACCUM, DIV_X, DIV_Y, PUBLISH.
  - ACCUM -> DIV_X at frame end if snapshot count != 0.
  - ACCUM -> PUBLISH if snapshot count == 0.
  - DIV_X -> DIV_Y, and DIV_Y -> PUBLISH, each when the divider reports done.
  - PUBLISH -> ACCUM after one cycle.
- Divider: restoring, 1 load cycle + SUM_W iterations = SUM_W+1 cycles per divide. Quotient truncated to 10 bits; it never exceeds 10 bits by construction.
- Latency with defaults:
  - Nonzero count: oSTAT_VALID is high in the cycle after edge T+2*(SUM_W+1)+1 = T+59.
  - Zero count: oSTAT_VALID at T+1, with oCX=oCY=0 and oEMPTY=1.
- Output registers (oCOUNT/oCX/oCY/oEMPTY) update only in PUBLISH and hold otherwise.
- oBUSY=1 in DIV_X and DIV_Y.
- Overrun: a frame end while the FSM is not in ACCUM sets oOVERRUN until reset.
  - That frame's snapshot is discarded; its accumulators are still cleared.
  - The in-flight result completes normally.
- Simultaneous PUBLISH and frame end: treated as not-in-ACCUM, so it counts as an overrun.
- Accumulators cannot overflow with the default parameters; no saturation logic is required.

Optional Feature:
- FRAME_STATS_BBOX_EN defined:
  - Adds oXMIN, oXMAX, oYMIN, oYMAX (10 bits each), tracked over light pixels.
  - Snapshotted and published with the same timing as oCX/oCY.
  - Empty frame publishes all four as 0.
  - Reset value 0.
- Not defined: ports and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package holds:
  - FSM state enum.
  - H_ACTIVE/V_ACTIVE defaults and derived widths (CNT_W, SUM_W, coordinate width 10).
  - Divider cycle-count constant.
- One sub-module: serial_divider (start/done handshake, dividend SUM_W, divisor CNT_W, quotient 10 bits). It is instantiated once and reused for X then Y.

Test Plan:
- Single light pixel 900 at (200,150), iTHRESH=512, all others 0 -> oCOUNT=1, oCX=200, oCY=150, oEMPTY=0, strobe at T+59.
- All-zero frame -> oCOUNT=0, oCX=oCY=0, oEMPTY=1, strobe at T+1, oBUSY never high.
- All pixels in X 160..479, Y 120..190 equal to 1023 -> oCOUNT=22720, oCX=319 (floor of 319.5), oCY=155.
- iTHRESH=300: pixel 300 at (10,10) and 299 at (20,20) -> oCOUNT=1, oCX=10, oCY=10.
- Assert iRST at DIV_Y cycle 5 -> next edge all outputs 0, no strobe. The following frame publishes correctly.
- H_ACTIVE=4, V_ACTIVE=2, back-to-back frames with a light pixel each -> second frame end during DIV_X sets oOVERRUN=1 (sticky). The first result publishes; the third frame publishes normally.
